// File: rtl/icache_assoc.sv
// N-way set-associative read-only instruction cache with a single-block refill FSM,
// whole-cache invalidate and saturating hit/miss counters.
module icache_assoc #(
  parameter int ADDR_W = 10,
  parameter int WORDS  = 4,
  parameter int SETS   = 4,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [31:0]                         address_pc,
  output logic [31:0]                         instruction,
  output logic                                busywait,
  input  logic                                invalidate,
  output logic                                imem_read,
  output logic [ADDR_W-$clog2(WORDS)-3:0]     imem_address,
  input  logic [32*WORDS-1:0]                 imem_readdata,
  input  logic                                imem_busywait,
  output logic [CNT_W-1:0]                    hit_count,
  output logic [CNT_W-1:0]                    miss_count
);
  localparam int OB = $clog2(WORDS) + 2;
  localparam int IB = $clog2(SETS);
  localparam int TB = ADDR_W - OB - IB;
  localparam int BW = ADDR_W - OB;
  localparam int OW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;
  state_t r_state, w_next;

  logic [WORDS-1:0][31:0] r_data  [SETS][WAYS];
  logic [TB-1:0]          r_tag   [SETS][WAYS];
  logic [WAYS-1:0]        r_valid [SETS];
  logic [WB-1:0]          r_rr    [SETS];
  logic [SETS-1:0]        r_lru;     // per set: index of the least-recently-used way (2-way only)
  logic                   r_inv_pend;
  logic                   r_first;   // first IDLE cycle after a fill; its hit belongs to the miss
  logic [CNT_W-1:0]       r_hits, r_misses;

  logic          w_fetch, w_hit, w_full;
  logic [IB-1:0] w_idx;
  logic [TB-1:0] w_tag;
  logic [OW-1:0] w_off;
  logic [BW-1:0] w_blk;
  logic [WB-1:0] w_hit_way, w_vict;

  assign w_fetch = (address_pc != 32'hFFFF_FFFC);
  assign w_idx   = IB'(address_pc >> OB);
  assign w_tag   = TB'(address_pc >> (OB + IB));
  assign w_off   = OW'((address_pc >> 2) & 32'(WORDS - 1));
  assign w_blk   = BW'(address_pc >> OB);

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
        w_hit     = w_fetch;
        w_hit_way = WB'(w);
      end
  end

  assign instruction = r_data[w_idx][w_hit_way][w_off];

  // Lowest invalid way wins; a full set falls back to LRU (2-way) or round-robin (>2-way).
  always_comb begin
    w_full = 1'b1;
    if (WAYS == 1)      w_vict = '0;
    else if (WAYS == 2) w_vict = WB'(r_lru[w_idx]);
    else                w_vict = r_rr[w_idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!r_valid[w_idx][w]) begin
        w_full = 1'b0;
        w_vict = WB'(w);
      end
  end

  always_comb begin
    w_next       = r_state;
    busywait     = 1'b0;
    imem_read    = 1'b0;
    imem_address = '0;
    case (r_state)
      S_IDLE: if (w_fetch && !w_hit) begin
        busywait = 1'b1;
        w_next   = S_MEM_READ;
      end
      S_MEM_READ: begin
        busywait     = 1'b1;
        imem_read    = 1'b1;
        imem_address = w_blk;
        if (!imem_busywait) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        busywait     = 1'b1;
        imem_address = w_blk;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_inv_pend <= 1'b0;
      r_first    <= 1'b0;
      r_hits     <= '0;
      r_misses   <= '0;
      r_lru      <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      r_state <= w_next;
      r_first <= (r_state == S_UPDATE);
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            if (!r_first && r_hits != '1) r_hits <= r_hits + CNT_W'(1);
            if (WAYS == 2) r_lru[w_idx] <= ~w_hit_way[0];
          end
          if (w_fetch && !w_hit && r_misses != '1) r_misses <= r_misses + CNT_W'(1);
          // Clearing after the LRU touch lets the invalidate override it.
          if (invalidate || r_inv_pend) begin
            r_inv_pend <= 1'b0;
            r_lru      <= '0;
            for (int s = 0; s < SETS; s++) begin
              r_valid[s] <= '0;
              r_rr[s]    <= '0;
            end
          end
        end
        S_MEM_READ: if (invalidate) r_inv_pend <= 1'b1;
        S_UPDATE: begin
          if (invalidate) r_inv_pend <= 1'b1;
          r_data[w_idx][w_vict]  <= imem_readdata;
          r_tag[w_idx][w_vict]   <= w_tag;
          r_valid[w_idx][w_vict] <= 1'b1;
          if (WAYS == 2) r_lru[w_idx] <= ~w_vict[0];
          if (WAYS > 2 && w_full) r_rr[w_idx] <= r_rr[w_idx] + WB'(1);
        end
        default: ;
      endcase
    end
  end

  assign hit_count  = r_hits;
  assign miss_count = r_misses;
endmodule
